// File: rtl/robot_pkg.sv
// Shared encodings for the robot motion controller: cell codes, headings,
// command and response encodings, FSM states and map size defaults.
package robot_pkg;

    localparam int MAP_W_DEFAULT = 20;
    localparam int MAP_H_DEFAULT = 10;

    localparam logic [3:0] CELL_FREE   = 4'd0;
    localparam logic [3:0] CELL_WALL   = 4'd1;
    localparam logic [3:0] CELL_BLACK  = 4'd2;
    localparam logic [3:0] CELL_LIGHT  = 4'd3;
    localparam logic [3:0] CELL_MEDIUM = 4'd4;
    localparam logic [3:0] CELL_HEAVY  = 4'd5;

    localparam logic [1:0] DIR_N = 2'd0;
    localparam logic [1:0] DIR_W = 2'd1;
    localparam logic [1:0] DIR_S = 2'd2;
    localparam logic [1:0] DIR_E = 2'd3;

    localparam logic [1:0] CMD_FORWARD    = 2'd0;
    localparam logic [1:0] CMD_TURN_LEFT  = 2'd1;
    localparam logic [1:0] CMD_TURN_RIGHT = 2'd2;
    localparam logic [1:0] CMD_CLEAR      = 2'd3;

    localparam logic [1:0] ST_OK               = 2'd0;
    localparam logic [1:0] ST_BLOCKED_BOUND    = 2'd1;
    localparam logic [1:0] ST_BLOCKED_CELL     = 2'd2;
    localparam logic [1:0] ST_NOTHING_TO_CLEAR = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_CHECK = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    // Free and black cells can be driven over; everything else blocks.
    function automatic logic is_passable(input logic [3:0] code);
        return (code == CELL_FREE) || (code == CELL_BLACK);
    endfunction

    // Light, medium and heavy debris are the only clearable codes.
    function automatic logic is_debris(input logic [3:0] code);
        return (code == CELL_LIGHT) || (code == CELL_MEDIUM) || (code == CELL_HEAVY);
    endfunction

    // One clearing pass lowers debris by one grade; light debris becomes free.
    function automatic logic [3:0] cleared_code(input logic [3:0] code);
        logic [3:0] res;
        case (code)
            CELL_HEAVY:  res = CELL_MEDIUM;
            CELL_MEDIUM: res = CELL_LIGHT;
            default:     res = CELL_FREE;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/front_cell_calc.sv
// Combinational front-cell calculator: the cell one step ahead of the robot
// along its heading, plus a flag when that step leaves the map. Arithmetic
// carries one extra sign bit so stepping off either edge never wraps.
module front_cell_calc
    import robot_pkg::*;
#(
    parameter int MAP_W = MAP_W_DEFAULT,
    parameter int MAP_H = MAP_H_DEFAULT
) (
    input  logic [4:0] xr_i,
    input  logic [3:0] yr_i,
    input  logic [1:0] dr_i,
    output logic [4:0] fx_o,
    output logic [3:0] fy_o,
    output logic       oob_o
);

    logic signed [5:0] fx_s;
    logic signed [4:0] fy_s;

    // Step one cell along the heading in sign-extended coordinates.
    always_comb begin
        fx_s = $signed({1'b0, xr_i});
        fy_s = $signed({1'b0, yr_i});
        case (dr_i)
            DIR_N:   fy_s = fy_s - 5'sd1;
            DIR_W:   fx_s = fx_s - 6'sd1;
            DIR_S:   fy_s = fy_s + 5'sd1;
            default: fx_s = fx_s + 6'sd1;
        endcase
    end

    assign fx_o  = fx_s[4:0];
    assign fy_o  = fy_s[3:0];
    assign oob_o = fx_s[5] || fy_s[4]
                || (fx_s >= $signed(6'(MAP_W)))
                || (fy_s >= $signed(5'(MAP_H)));

endmodule

// File: rtl/robot_motion_ctrl.sv
// Robot motion controller: owns the robot pose shown by the map renderer and
// executes one FORWARD / TURN / CLEAR command at a time, checking the target
// cell through a 1-cycle-latency map read port and writing cleared debris back.
// Optional build macro MOVE_COUNT_EN adds a saturating move_cnt output that
// counts successful FORWARD moves.
module robot_motion_ctrl #(
    parameter int MAP_W     = robot_pkg::MAP_W_DEFAULT,
    parameter int MAP_H     = robot_pkg::MAP_H_DEFAULT,
    parameter int START_X   = 0,
    parameter int START_Y   = 0,
    parameter int START_DIR = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [1:0] cmd,
    output logic       cmd_ready,
    output logic       map_rd_en,
    output logic [4:0] map_rd_x,
    output logic [3:0] map_rd_y,
    input  logic [3:0] map_rd_data,
    output logic       map_wr_en,
    output logic [4:0] map_wr_x,
    output logic [3:0] map_wr_y,
    output logic [3:0] map_wr_data,
    output logic [4:0] xr,
    output logic [3:0] yr,
    output logic [1:0] dr,
    output logic       resp_valid,
    output logic [1:0] resp_status
`ifdef MOVE_COUNT_EN
    ,
    output logic [15:0] move_cnt
`endif
);

    import robot_pkg::*;

    state_t     state_q;
    logic [1:0] cmd_q;
    logic [4:0] fx_q;
    logic [3:0] fy_q;
    logic [4:0] xr_q;
    logic [3:0] yr_q;
    logic [1:0] dr_q;
    logic [4:0] nx_q;
    logic [3:0] ny_q;
    logic [1:0] nd_q;
    logic       cmd_ready_q;
    logic       rd_en_q;
    logic       wr_en_q;
    logic [3:0] wr_data_q;
    logic       resp_valid_q;
    logic [1:0] status_q;

    logic [4:0] front_x;
    logic [3:0] front_y;
    logic       front_oob;

    logic [1:0] chk_status_d;
    logic       chk_move_d;
    logic       chk_wr_d;
    logic [3:0] chk_wdata_d;

    front_cell_calc #(
        .MAP_W (MAP_W),
        .MAP_H (MAP_H)
    ) u_front (
        .xr_i  (xr_q),
        .yr_i  (yr_q),
        .dr_i  (dr_q),
        .fx_o  (front_x),
        .fy_o  (front_y),
        .oob_o (front_oob)
    );

    // Decide the outcome of a FORWARD or CLEAR from the cell code returned by the map.
    always_comb begin
        chk_status_d = ST_OK;
        chk_move_d   = 1'b0;
        chk_wr_d     = 1'b0;
        chk_wdata_d  = cleared_code(map_rd_data);
        if (cmd_q == CMD_FORWARD) begin
            if (is_passable(map_rd_data)) begin
                chk_move_d = 1'b1;
            end else begin
                chk_status_d = ST_BLOCKED_CELL;
            end
        end else begin
            if (is_debris(map_rd_data)) begin
                chk_wr_d = 1'b1;
            end else begin
                chk_status_d = ST_NOTHING_TO_CLEAR;
            end
        end
    end

    // Command FSM; the new pose is staged in nx/ny/nd and committed only when leaving RESP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cmd_q        <= CMD_FORWARD;
            fx_q         <= '0;
            fy_q         <= '0;
            xr_q         <= 5'(START_X);
            yr_q         <= 4'(START_Y);
            dr_q         <= 2'(START_DIR);
            nx_q         <= 5'(START_X);
            ny_q         <= 4'(START_Y);
            nd_q         <= 2'(START_DIR);
            cmd_ready_q  <= 1'b1;
            rd_en_q      <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_data_q    <= '0;
            resp_valid_q <= 1'b0;
            status_q     <= ST_OK;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready_q) begin
                        cmd_q       <= cmd;
                        cmd_ready_q <= 1'b0;
                        nx_q        <= xr_q;
                        ny_q        <= yr_q;
                        nd_q        <= dr_q;
                        if (cmd == CMD_TURN_LEFT || cmd == CMD_TURN_RIGHT) begin
                            nd_q         <= (cmd == CMD_TURN_LEFT) ? dr_q + 2'd1 : dr_q - 2'd1;
                            status_q     <= ST_OK;
                            resp_valid_q <= 1'b1;
                            state_q      <= S_RESP;
                        end else if (front_oob) begin
                            status_q     <= ST_BLOCKED_BOUND;
                            resp_valid_q <= 1'b1;
                            state_q      <= S_RESP;
                        end else begin
                            fx_q    <= front_x;
                            fy_q    <= front_y;
                            rd_en_q <= 1'b1;
                            state_q <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    rd_en_q <= 1'b0;
                    state_q <= S_CHECK;
                end
                S_CHECK: begin
                    status_q     <= chk_status_d;
                    resp_valid_q <= 1'b1;
                    wr_en_q      <= chk_wr_d;
                    if (chk_wr_d) begin
                        wr_data_q <= chk_wdata_d;
                    end
                    if (chk_move_d) begin
                        nx_q <= fx_q;
                        ny_q <= fy_q;
                    end
                    state_q <= S_RESP;
                end
                default: begin
                    resp_valid_q <= 1'b0;
                    wr_en_q      <= 1'b0;
                    xr_q         <= nx_q;
                    yr_q         <= ny_q;
                    dr_q         <= nd_q;
                    cmd_ready_q  <= 1'b1;
                    state_q      <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign map_rd_en   = rd_en_q;
    assign map_rd_x    = fx_q;
    assign map_rd_y    = fy_q;
    assign map_wr_en   = wr_en_q;
    assign map_wr_x    = fx_q;
    assign map_wr_y    = fy_q;
    assign map_wr_data = wr_data_q;
    assign xr          = xr_q;
    assign yr          = yr_q;
    assign dr          = dr_q;
    assign resp_valid  = resp_valid_q;
    assign resp_status = status_q;

`ifdef MOVE_COUNT_EN
    logic [15:0] move_cnt_q;

    // Count FORWARD moves that complete OK, holding at the maximum value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            move_cnt_q <= '0;
        end else if (state_q == S_RESP && cmd_q == CMD_FORWARD && status_q == ST_OK
                     && move_cnt_q != 16'hFFFF) begin
            move_cnt_q <= move_cnt_q + 16'd1;
        end
    end

    assign move_cnt = move_cnt_q;
`endif

endmodule

// File: tb/tb_robot_motion_ctrl.sv
// Directed bench for robot_motion_ctrl with a behavioural 1-cycle map RAM.
module tb_robot_motion_ctrl;

    localparam logic [1:0] F = 2'd0, L = 2'd1, R = 2'd2, C = 2'd3;
    localparam int OK = 0, BB = 1, BC = 2, NC = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd = 2'd0;
    logic       cmd_ready;
    logic       map_rd_en;
    logic [4:0] map_rd_x;
    logic [3:0] map_rd_y;
    logic [3:0] map_rd_data = 4'd0;
    logic       map_wr_en;
    logic [4:0] map_wr_x;
    logic [3:0] map_wr_y;
    logic [3:0] map_wr_data;
    logic [4:0] xr;
    logic [3:0] yr;
    logic [1:0] dr;
    logic       resp_valid;
    logic [1:0] resp_status;
`ifdef MOVE_COUNT_EN
    logic [15:0] move_cnt;
`endif

    robot_motion_ctrl #(
        .MAP_W(20), .MAP_H(10), .START_X(0), .START_Y(0), .START_DIR(0)
    ) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready),
        .map_rd_en(map_rd_en), .map_rd_x(map_rd_x), .map_rd_y(map_rd_y),
        .map_rd_data(map_rd_data), .map_wr_en(map_wr_en), .map_wr_x(map_wr_x),
        .map_wr_y(map_wr_y), .map_wr_data(map_wr_data), .xr(xr), .yr(yr), .dr(dr),
        .resp_valid(resp_valid), .resp_status(resp_status)
`ifdef MOVE_COUNT_EN
        , .move_cnt(move_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Map RAM model: registered read, write on the clock edge.
    logic [3:0] mem [0:19][0:9];
    always @(posedge clk) begin
        if (map_rd_en) map_rd_data <= mem[map_rd_x][map_rd_y];
        if (map_wr_en) mem[map_wr_x][map_wr_y] = map_wr_data;
    end

    // Activity monitor sampled on the falling edge.
    int rd_cnt = 0, wr_cnt = 0, both_cnt = 0, resp_cnt = 0;
    int rd_lx = 0, rd_ly = 0, wr_lx = 0, wr_ly = 0, wr_ld = 0;
    always @(negedge clk) begin
        if (rst) begin
            if (map_rd_en) begin rd_cnt++; rd_lx = map_rd_x; rd_ly = map_rd_y; end
            if (map_wr_en) begin wr_cnt++; wr_lx = map_wr_x; wr_ly = map_wr_y; wr_ld = map_wr_data; end
            if (map_rd_en && map_wr_en) both_cnt++;
            if (resp_valid) resp_cnt++;
        end
    end

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Offer one command when ready, return latency (accept cycle = 1) and status.
    task automatic issue(input logic [1:0] c, output int lat, output int st);
        int n;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
        cmd = c;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        lat = 1;
        do begin @(negedge clk); lat++; end while (!resp_valid && lat < 12);
        st = resp_valid ? int'(resp_status) : -1;
        @(negedge clk);
    endtask

    typedef struct {
        logic [1:0] c;
        bit         se;
        int         sx, sy, sv;
        int         est, elat, ex, ey, ed;
        bit         erd, ewr;
        int         ewd, fx, fy;
    } vec_t;

    function automatic vec_t mk(logic [1:0] c, bit se, int sx, int sy, int sv, int est, int elat,
                                int ex, int ey, int ed, bit erd, bit ewr, int ewd, int fx, int fy);
        vec_t v;
        v.c = c; v.se = se; v.sx = sx; v.sy = sy; v.sv = sv; v.est = est; v.elat = elat;
        v.ex = ex; v.ey = ey; v.ed = ed; v.erd = erd; v.ewr = ewr; v.ewd = ewd; v.fx = fx; v.fy = fy;
        return v;
    endfunction

    localparam int NV = 23;
    vec_t tv [NV];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, st, rd0, wr0, rs0;

        for (int x = 0; x < 20; x++)
            for (int y = 0; y < 10; y++)
                mem[x][y] = 4'd0;

        //           cmd se sx sy sv  st lat  x  y  d rd wr wd fx fy
        tv[0]  = mk(R, 0, 0, 0, 0, OK, 2, 0, 0, 3, 0, 0, 0, 0, 0);
        tv[1]  = mk(R, 0, 0, 0, 0, OK, 2, 0, 0, 2, 0, 0, 0, 0, 0);
        tv[2]  = mk(L, 0, 0, 0, 0, OK, 2, 0, 0, 3, 0, 0, 0, 0, 0);
        tv[3]  = mk(L, 0, 0, 0, 0, OK, 2, 0, 0, 0, 0, 0, 0, 0, 0);
        tv[4]  = mk(F, 0, 0, 0, 0, BB, 2, 0, 0, 0, 0, 0, 0, 0, 0);
        tv[5]  = mk(C, 0, 0, 0, 0, BB, 2, 0, 0, 0, 0, 0, 0, 0, 0);
        tv[6]  = mk(L, 0, 0, 0, 0, OK, 2, 0, 0, 1, 0, 0, 0, 0, 0);
        tv[7]  = mk(F, 0, 0, 0, 0, BB, 2, 0, 0, 1, 0, 0, 0, 0, 0);
        tv[8]  = mk(L, 0, 0, 0, 0, OK, 2, 0, 0, 2, 0, 0, 0, 0, 0);
        tv[9]  = mk(F, 1, 0, 1, 1, BC, 4, 0, 0, 2, 1, 0, 0, 0, 1);
        tv[10] = mk(F, 1, 0, 1, 0, OK, 4, 0, 1, 2, 1, 0, 0, 0, 1);
        tv[11] = mk(F, 1, 0, 2, 2, OK, 4, 0, 2, 2, 1, 0, 0, 0, 2);
        tv[12] = mk(F, 1, 0, 3, 7, BC, 4, 0, 2, 2, 1, 0, 0, 0, 3);
        tv[13] = mk(C, 0, 0, 0, 0, NC, 4, 0, 2, 2, 1, 0, 0, 0, 3);
        tv[14] = mk(L, 0, 0, 0, 0, OK, 2, 0, 2, 3, 0, 0, 0, 0, 0);
        tv[15] = mk(F, 0, 0, 0, 0, OK, 4, 1, 2, 3, 1, 0, 0, 1, 2);
        tv[16] = mk(F, 0, 0, 0, 0, OK, 4, 2, 2, 3, 1, 0, 0, 2, 2);
        tv[17] = mk(F, 0, 0, 0, 0, OK, 4, 3, 2, 3, 1, 0, 0, 3, 2);
        tv[18] = mk(C, 1, 4, 2, 5, OK, 4, 3, 2, 3, 1, 1, 4, 4, 2);
        tv[19] = mk(C, 0, 0, 0, 0, OK, 4, 3, 2, 3, 1, 1, 3, 4, 2);
        tv[20] = mk(C, 0, 0, 0, 0, OK, 4, 3, 2, 3, 1, 1, 0, 4, 2);
        tv[21] = mk(C, 0, 0, 0, 0, NC, 4, 3, 2, 3, 1, 0, 0, 4, 2);
        tv[22] = mk(F, 0, 0, 0, 0, OK, 4, 4, 2, 3, 1, 0, 0, 4, 2);

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset xr", xr, 0);
        chk("reset yr", yr, 0);
        chk("reset dr", dr, 0);
        chk("reset cmd_ready", cmd_ready, 1);
        chk("reset resp_valid", resp_valid, 0);
        chk("reset rd_en", map_rd_en, 0);
        chk("reset wr_en", map_wr_en, 0);
        chk("reset status", resp_status, 0);
        rst = 1'b1;

        // Table-driven command sequence
        for (int i = 0; i < NV; i++) begin
            if (tv[i].se) mem[tv[i].sx][tv[i].sy] = 4'(tv[i].sv);
            rd0 = rd_cnt;
            wr0 = wr_cnt;
            issue(tv[i].c, lat, st);
            chk($sformatf("v%0d status", i), st, tv[i].est);
            chk($sformatf("v%0d latency", i), lat, tv[i].elat);
            chk($sformatf("v%0d xr", i), xr, tv[i].ex);
            chk($sformatf("v%0d yr", i), yr, tv[i].ey);
            chk($sformatf("v%0d dr", i), dr, tv[i].ed);
            chk($sformatf("v%0d rd pulses", i), rd_cnt - rd0, tv[i].erd ? 1 : 0);
            chk($sformatf("v%0d wr pulses", i), wr_cnt - wr0, tv[i].ewr ? 1 : 0);
            if (tv[i].erd) begin
                chk($sformatf("v%0d rd_x", i), rd_lx, tv[i].fx);
                chk($sformatf("v%0d rd_y", i), rd_ly, tv[i].fy);
            end
            if (tv[i].ewr) begin
                chk($sformatf("v%0d wr_data", i), wr_ld, tv[i].ewd);
                chk($sformatf("v%0d wr_x", i), wr_lx, tv[i].fx);
                chk($sformatf("v%0d wr_y", i), wr_ly, tv[i].fy);
            end
        end
        chk("cleared cell", mem[4][2], 0);

        // Drive to the far corner (19,9)
        for (int k = 5; k <= 19; k++) begin
            issue(F, lat, st);
            chk($sformatf("east step %0d status", k), st, OK);
            chk($sformatf("east step %0d xr", k), xr, k);
        end
        rd0 = rd_cnt;
        issue(F, lat, st);
        chk("east edge status", st, BB);
        chk("east edge latency", lat, 2);
        chk("east edge rd pulses", rd_cnt - rd0, 0);
        issue(R, lat, st);
        chk("turn south dr", dr, 2);
        for (int k = 3; k <= 9; k++) begin
            issue(F, lat, st);
            chk($sformatf("south step %0d yr", k), yr, k);
        end
        issue(F, lat, st);
        chk("south edge status", st, BB);
        chk("south edge yr", yr, 9);
        issue(L, lat, st);
        chk("corner dr E", dr, 3);
        rd0 = rd_cnt;
        issue(F, lat, st);
        chk("corner E status", st, BB);
        chk("corner E xr", xr, 19);
        chk("corner E rd pulses", rd_cnt - rd0, 0);
        issue(L, lat, st);
        chk("corner dr N", dr, 0);

        // cmd_valid held high through a fetch
        mem[19][8] = 4'd1;
        rd0 = rd_cnt;
        rs0 = resp_cnt;
        @(negedge clk);
        chk("hold ready idle", cmd_ready, 1);
        cmd = F;
        cmd_valid = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk($sformatf("hold ready busy c%0d", k), cmd_ready, 0);
        end
        chk("hold resp_valid", resp_valid, 1);
        chk("hold status", resp_status, BC);
        cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("hold rd pulses", rd_cnt - rd0, 1);
        chk("hold resp pulses", resp_cnt - rs0, 1);
        chk("hold ready back", cmd_ready, 1);
        chk("hold yr", yr, 9);

        // Reset in CHECK of a CLEAR on debris
        mem[19][8] = 4'd5;
        wr0 = wr_cnt;
        rs0 = resp_cnt;
        cmd = C;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("abort fetch rd_en", map_rd_en, 1);
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        chk("abort xr", xr, 0);
        chk("abort yr", yr, 0);
        chk("abort dr", dr, 0);
        chk("abort cmd_ready", cmd_ready, 1);
        chk("abort resp_valid", resp_valid, 0);
        chk("abort wr_en", map_wr_en, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort wr pulses", wr_cnt - wr0, 0);
        chk("abort resp pulses", resp_cnt - rs0, 0);
        chk("abort cell kept", mem[19][8], 5);
        chk("abort pose x", xr, 0);

`ifdef MOVE_COUNT_EN
        chk("move_cnt after reset", move_cnt, 0);
        issue(R, lat, st);
        issue(R, lat, st);
        mem[0][3] = 4'd0;
        mem[0][4] = 4'd1;
        for (int k = 1; k <= 3; k++) begin
            issue(F, lat, st);
            chk($sformatf("count fwd %0d", k), move_cnt, k);
        end
        issue(F, lat, st);
        chk("count blocked status", st, BC);
        chk("count after blocked", move_cnt, 3);
`endif

        chk("rd and wr overlap cycles", both_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
